// File: rtl/wordmon_tx_pkg.sv
// Shared constants, formatter state encoding and hex-digit helper for the
// word-change monitor and its UART reporter.
package wordmon_tx_pkg;

    localparam logic [7:0] ASCII_C     = 8'h63;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        FMT_IDLE,
        FMT_HDR,
        FMT_DIGITS,
        FMT_CR,
        FMT_LF
    } fmt_state_e;

    // Uppercase ASCII for one nibble: '0'..'9' then 'A'..'F'.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/wordmon_tx_txuart.sv
// 8N1 byte serializer. Busy drops during the final stop-bit cycle so a byte
// offered then starts exactly when the stop bit ends (no idle gap).
module txuart #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd1250
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_stb,
    input  logic [7:0] i_byte,
    output logic       o_busy,
    output logic       o_uart_tx
);

    logic        active_q;
    logic [3:0]  bit_q;
    logic [23:0] baud_q;
    logic [8:0]  sh_q;
    logic        tx_q;
    logic        last;

    // bit_q: 0 = start, 1..8 = data, 9 = stop
    assign last      = (bit_q == 4'd9) && (baud_q == 24'd0);
    assign o_busy    = active_q && !last;
    assign o_uart_tx = tx_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            active_q <= 1'b0;
            bit_q    <= 4'd0;
            baud_q   <= 24'd0;
            sh_q     <= '1;
            tx_q     <= 1'b1;
        end else if (i_stb && !o_busy) begin
            active_q <= 1'b1;
            bit_q    <= 4'd0;
            baud_q   <= CLOCKS_PER_BAUD - 24'd1;
            sh_q     <= {1'b1, i_byte};
            tx_q     <= 1'b0;
        end else if (active_q) begin
            if (last) begin
                active_q <= 1'b0;
            end else if (baud_q == 24'd0) begin
                bit_q  <= bit_q + 4'd1;
                baud_q <= CLOCKS_PER_BAUD - 24'd1;
                tx_q   <= sh_q[0];
                sh_q   <= {1'b1, sh_q[8:1]};
            end else begin
                baud_q <= baud_q - 24'd1;
            end
        end
    end

endmodule

// File: rtl/wordmon_tx.sv
// Watches NCH words for changes and reports each changed word over UART as
// "c<ch>:<hex word>\r\n", serving pending channels round-robin.
module wordmon_tx
    import wordmon_tx_pkg::*;
#(
    parameter int          NCH             = 4,
    parameter int          DW              = 32,
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd1250
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NCH*DW-1:0] i_data,
    output logic              o_uart_tx,
    output logic              o_busy,
    output logic [NCH-1:0]    o_pending,
    output logic [NCH-1:0]    o_overrun
);

    localparam int ND = DW / 4;

    logic [NCH-1:0][DW-1:0] hold_vec;
    logic [NCH-1:0]         pend_vec, ovr_vec;
    fmt_state_e             state_q;
    logic [4:0]             idx_q;
    logic [3:0]             ch_q, last_q, sel;
    logic [DW-1:0]          shadow_q, load_val;
    logic                   load, stb, accept, ser_busy;
    logic [7:0]             tx_byte;

    assign load = (state_q == FMT_IDLE) && (|pend_vec);

    // Later writes win: lowest index after last_q beats any wrapped index.
    always_comb begin
        sel = 4'd0;
        for (int j = NCH - 1; j >= 0; j--)
            if (pend_vec[j] && (4'(j) <= last_q)) sel = 4'(j);
        for (int j = NCH - 1; j >= 0; j--)
            if (pend_vec[j] && (4'(j) > last_q)) sel = 4'(j);
    end

    always_comb begin
        load_val = '0;
        for (int j = 0; j < NCH; j++)
            if (sel == 4'(j)) load_val = hold_vec[j];
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [DW-1:0] smp, prev_q, hold_q;
        logic          chg, taken, pend_q, ovr_q;

        assign smp   = i_data[c*DW +: DW];
        assign chg   = (smp != prev_q);
        assign taken = load && (sel == 4'(c));

        // A change landing on the load edge re-arms pending without overrun.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                prev_q <= '0;
                hold_q <= '0;
                pend_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else begin
                prev_q <= smp;
                if (chg) hold_q <= smp;
                pend_q <= chg | (pend_q & ~taken);
                ovr_q  <= ovr_q | (chg & pend_q & ~taken);
            end
        end

        assign hold_vec[c] = hold_q;
        assign pend_vec[c] = pend_q;
        assign ovr_vec[c]  = ovr_q;
    end

    assign stb    = (state_q != FMT_IDLE);
    assign accept = stb && !ser_busy;

    always_comb begin
        tx_byte = ASCII_LF;
        case (state_q)
            FMT_HDR:    tx_byte = (idx_q == 5'd0) ? ASCII_C :
                                  (idx_q == 5'd1) ? hex_ascii(ch_q) : ASCII_COLON;
            FMT_DIGITS: tx_byte = hex_ascii(shadow_q[DW-1 -: 4]);
            FMT_CR:     tx_byte = ASCII_CR;
            default:    tx_byte = ASCII_LF;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= FMT_IDLE;
            idx_q    <= 5'd0;
            ch_q     <= 4'd0;
            last_q   <= 4'(NCH - 1);
            shadow_q <= '0;
        end else begin
            case (state_q)
                FMT_IDLE: if (load) begin
                    state_q  <= FMT_HDR;
                    idx_q    <= 5'd0;
                    ch_q     <= sel;
                    last_q   <= sel;
                    shadow_q <= load_val;
                end
                FMT_HDR: if (accept) begin
                    if (idx_q == 5'd2) begin
                        state_q <= FMT_DIGITS;
                        idx_q   <= 5'd0;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                FMT_DIGITS: if (accept) begin
                    shadow_q <= shadow_q << 4;
                    if (idx_q == 5'(ND - 1)) state_q <= FMT_CR;
                    else                     idx_q   <= idx_q + 5'd1;
                end
                FMT_CR:  if (accept) state_q <= FMT_LF;
                FMT_LF:  if (accept) state_q <= FMT_IDLE;
                default: state_q <= FMT_IDLE;
            endcase
        end
    end

    txuart #(
        .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
    ) u_txuart (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_stb    (stb),
        .i_byte   (tx_byte),
        .o_busy   (ser_busy),
        .o_uart_tx(o_uart_tx)
    );

    assign o_busy    = stb | ser_busy;
    assign o_pending = pend_vec;
    assign o_overrun = ovr_vec;

endmodule

// File: tb/tb_wordmon_tx.sv
// Scoreboard bench: directed channel changes push expected message bytes;
// a UART line decoder pops and compares each received byte.
module tb_wordmon_tx;

    localparam int CPB = 4;

    typedef struct packed {
        logic [7:0] b;
        logic       contig;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] data;
    logic         tx, busy;
    logic [3:0]   pend, ovr;
    longint       cyc = 0;
    int           total = 0;
    int           bad = 0;
    exp_t         exp_q[$];

    wordmon_tx #(
        .NCH(4),
        .DW(32),
        .CLOCKS_PER_BAUD(24'd4)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_data   (data),
        .o_uart_tx(tx),
        .o_busy   (busy),
        .o_pending(pend),
        .o_overrun(ovr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        data[c*32 +: 32] = v;
    endtask

    task automatic push_msg(input string s, input bit contig);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.b      = s[i];
            e.contig = (i == 0) ? contig : 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            n++;
            tick();
        end
        chk(name, 32'(n < budget), 1);
    endtask

    // Line decoder: samples mid-bit on the falling clock edge.
    initial begin
        int         cnt;
        logic       act;
        logic [7:0] sh;
        longint     st, prev_st;
        exp_t       e;
        act = 1'b0; cnt = 0; sh = '0; st = 0; prev_st = -1000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx == 1'b0) begin
                    act = 1'b1; cnt = 0; st = cyc;
                end
            end else begin
                cnt++;
                if (cnt == CPB/2) begin
                    if (tx !== 1'b0) begin
                        chk("rx_start", 32'(tx), 0);
                        act = 1'b0;
                    end
                end else if (cnt > CPB/2 && cnt <= CPB/2 + 8*CPB && (cnt - CPB/2) % CPB == 0) begin
                    sh = {tx, sh[7:1]};
                end else if (cnt == CPB/2 + 9*CPB) begin
                    act = 1'b0;
                    chk("rx_stop", 32'(tx), 1);
                    if (exp_q.size() == 0) begin
                        chk("rx_unexpected_byte", 32'(sh), 'h100);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", 32'(sh), 32'(e.b));
                        if (e.contig) chk("rx_gap", 32'(st - prev_st), CPB*10);
                    end
                    prev_st = st;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, viol;
        rst_n = 1'b0;
        data  = '0;
        repeat (3) tick();
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_ovr", 32'(ovr), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // single message, latency and busy length
        push_msg("c0:1234ABCD\r\n", 1'b0);
        set_ch(0, 32'h1234ABCD);
        tick();
        chk("t1_pend_k", 32'(pend), 'b0001);
        chk("t1_busy_k", 32'(busy), 0);
        tick();
        chk("t1_busy_load", 32'(busy), 1);
        chk("t1_pend_load", 32'(pend), 0);
        chk("t1_tx_load", 32'(tx), 1);
        tick();
        chk("t1_start_bit", 32'(tx), 0);
        n = 1;
        while (busy && n < 2000) begin
            n++;
            tick();
        end
        chk("t1_busy_len", n, 520);
        wait_idle("t1_idle", 200);

        // two channels at once, back to back
        push_msg("c1:0000BEEF\r\n", 1'b0);
        push_msg("c3:CAFE0001\r\n", 1'b1);
        set_ch(1, 32'h0000BEEF);
        set_ch(3, 32'hCAFE0001);
        tick();
        chk("t2_pend_k", 32'(pend), 'b1010);
        tick();
        chk("t2_pend_load", 32'(pend), 'b1000);
        repeat (100) tick();
        chk("t2_pend_mid", 32'(pend), 'b1000);
        wait_idle("t2_idle", 3000);

        // overwrite while pending -> overrun
        push_msg("c1:11111111\r\n", 1'b0);
        push_msg("c2:00000002\r\n", 1'b1);
        set_ch(1, 32'h11111111);
        repeat (50) tick();
        set_ch(2, 32'h1);
        tick();
        set_ch(2, 32'h2);
        tick();
        tick();
        chk("t3_ovr_mid", 32'(ovr), 'b0100);
        chk("t3_pend_mid", 32'(pend), 'b0100);
        wait_idle("t3_idle", 3000);
        chk("t3_ovr_end", 32'(ovr), 'b0100);
        chk("t3_pend_end", 32'(pend), 0);

        // busy channel 0 must not starve channel 3
        push_msg("c0:00000100\r\n", 1'b0);
        push_msg("c3:00000033\r\n", 1'b1);
        push_msg("c0:000001C8\r\n", 1'b1);
        set_ch(0, 32'h100);
        for (int i = 1; i <= 200; i++) begin
            tick();
            set_ch(0, 32'h100 + 32'(i));
            if (i == 2) set_ch(3, 32'h33);
        end
        tick();
        chk("t4_pend", 32'(pend), 'b1001);
        chk("t4_ovr", 32'(ovr), 'b0101);
        wait_idle("t4_idle", 5000);
        chk("t4_ovr_end", 32'(ovr), 'b0101);

        // constant inputs -> quiet line
        viol = 0;
        repeat (10000) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("t5_quiet", viol, 0);

        // reset in the middle of the third byte
        push_msg("c2", 1'b0);
        set_ch(2, 32'hDEAD0002);
        tick();
        tick();
        set_ch(1, 32'h5);
        repeat (95) tick();
        rst_n = 1'b0;
        data  = '0;
        #1;
        chk("t6_rst_tx", 32'(tx), 1);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_pend", 32'(pend), 0);
        chk("t6_rst_ovr", 32'(ovr), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        viol = 0;
        repeat (300) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        chk("t6_no_resume", viol, 0);
        chk("t6_queue", exp_q.size(), 0);

        // nonzero data across reset release, pointer restarts at channel 0
        rst_n = 1'b0;
        tick();
        set_ch(0, 32'hA5A5A5A5);
        set_ch(3, 32'h33);
        push_msg("c0:A5A5A5A5\r\n", 1'b0);
        push_msg("c3:00000033\r\n", 1'b1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t7_pend_k", 32'(pend), 'b1001);
        tick();
        chk("t7_pend_load", 32'(pend), 'b1000);
        wait_idle("t7_idle", 3000);
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
